// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 engine, one round per clock.
// Direction is chosen per block; key length is fixed by NK at elaboration.
// The round-key schedule is supplied flat on expanded_keys, round 0 in the MSBs.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high. in_ready is high in IDLE, and in DONE when out_ready is high.
// out_valid is high only in DONE, and out_data is then held stable until
// out_ready is seen. in_valid is ignored while rounds are running.
module aes_iter_core #(
    parameter int NK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    input  logic                   in_decrypt,
    input  logic [128*(NK+7)-1:0]  expanded_keys,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_data,
    output logic                   busy
);
    localparam int NR = NK + 6;
    localparam int CW = $clog2(NR + 1);
    localparam int KW = 128 * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_iter_core: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [127:0]    blk_q, out_q;
    logic [CW-1:0]   cnt_q;
    logic            mode_q;
    logic            accept, last;
    logic [127:0]    rk_enc, rk_dec, rk_first;
    logic [127:0]    enc_sr, enc_mc, dec_sr, dec_ark, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // Combinational S-box ROM contents: inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CW'(NR));
    assign out_data  = out_q;
    assign rk_enc    = expanded_keys[KW-1-128*int'(cnt_q) -: 128];
    assign rk_dec    = expanded_keys[KW-1-128*(NR-int'(cnt_q)) -: 128];
    assign rk_first  = in_decrypt ? expanded_keys[127:0] : expanded_keys[KW-1 -: 128];

    // Next-state and handshake outputs of the IDLE/RUN/DONE controller.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One full cipher or inverse-cipher round; byte i is row i%4, column i/4.
    always_comb begin
        enc_sr    = '0;
        enc_mc    = '0;
        dec_sr    = '0;
        dec_ark   = '0;
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            enc_sr[127-8*i -: 8] = sbox(blk_q[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]);
            dec_sr[127-8*i -: 8] = inv_sbox(blk_q[127-8*((i%4) + 4*(((i/4) - (i%4) + 4) % 4)) -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            enc_mc[127-32*c -: 32] = mix_col(enc_sr[127-32*c -: 32]);
        end
        dec_ark = dec_sr ^ rk_dec;
        if (mode_q) begin
            round_out = dec_ark;
            if (!last) begin
                for (int c = 0; c < 4; c++) begin
                    round_out[127-32*c -: 32] = inv_mix_col(dec_ark[127-32*c -: 32]);
                end
            end
        end else begin
            round_out = (last ? enc_sr : enc_mc) ^ rk_enc;
        end
    end

    // State register, round datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= in_decrypt;
                blk_q  <= in_data ^ rk_first;
                cnt_q  <= CW'(1);
            end else if (state_q == RUN) begin
                if (last) begin
                    out_q <= round_out;
                    cnt_q <= '0;
                end else begin
                    blk_q <= round_out;
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed bench for aes_iter_core at NK = 4, 6 and 8.
// Index 0 drives the NK=4 core, 1 the NK=6 core, 2 the NK=8 core.
module tb_aes_iter_core;
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY4 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    // Clock and reset.
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]          in_valid, in_decrypt, out_ready;
    logic [2:0]          in_ready, out_valid, busy;
    logic [127:0]        in_data  [3];
    logic [127:0]        out_data [3];
    logic [128*11-1:0]   ek4;
    logic [128*13-1:0]   ek6;
    logic [128*15-1:0]   ek8;
    logic [127:0]        exp_q [$];
    int                  n_checks = 0;
    int                  n_fail   = 0;

    aes_iter_core #(.NK(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_decrypt(in_decrypt[0]), .expanded_keys(ek4),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
    aes_iter_core #(.NK(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_decrypt(in_decrypt[1]), .expanded_keys(ek6),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
    aes_iter_core #(.NK(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_decrypt(in_decrypt[2]), .expanded_keys(ek8),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX_TAB[2047-8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // FIPS-197 key expansion; key is left-aligned, result has round key 0 in the MSBs.
    function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ek;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        ek = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            ek[1919-32*i -: 32] = w[i];
        end
        return ek;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Driver: offer one block, wait for the result, check it, optionally
    // stall the consumer for 'hold' cycles, then consume it.
    task automatic do_block(input int idx, input int nr, input logic [127:0] data,
                            input logic dec, input logic has_exp, input logic [127:0] expv,
                            input int hold, input string tag, output logic [127:0] res);
        int          lat;
        logic [127:0] want;
        chk({tag, "_in_ready"}, 128'(in_ready[idx]), 128'd1);
        in_valid[idx]   = 1'b1;
        in_data[idx]    = data;
        in_decrypt[idx] = dec;
        if (has_exp) exp_q.push_back(expv);
        @(negedge clk);
        in_valid[idx]   = 1'b0;
        in_data[idx]    = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt[idx] = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid[idx] && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, "_busy_run"}, 128'(busy[idx]), 128'd1);
        end
        chk({tag, "_latency"}, 128'(lat), 128'(nr));
        chk({tag, "_busy_done"}, 128'(busy[idx]), 128'd0);
        res = out_data[idx];
        if (has_exp) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk({tag, "_data"}, out_data[idx], want);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, out_data[idx], expv);
            chk({tag, "_hold_rdy_vld"}, 128'({in_ready[idx], out_valid[idx]}), 128'b01);
        end
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        chk({tag, "_consumed"}, 128'(out_valid[idx]), 128'd0);
    endtask

    // Directed sequence and scoreboard checks.
    initial begin
        logic [1919:0] full;
        logic [127:0]  res, rnd_pt, ct;
        logic [127:0]  b2b_data [4];
        logic [3:0]    b2b_dec;
        logic [127:0]  b2b_exp [4];
        logic [127:0]  want;
        int            sent, got, last_out, cyc, seen;

        reset      = 1'b1;
        in_valid   = '0;
        in_decrypt = '0;
        out_ready  = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        full = key_expand(KEY4, 4); ek4 = full[1919 -: 1408];
        full = key_expand(KEY6, 6); ek6 = full[1919 -: 1664];
        full = key_expand(KEY8, 8); ek8 = full;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk("reset_flags", 128'({in_ready[i], out_valid[i], busy[i]}), 128'b100);
            chk("reset_out_data", out_data[i], 128'd0);
        end

        // Known-answer vectors at all three key lengths, plus the inverse.
        do_block(0, 10, PT0, 1'b0, 1'b1, CT4, 0, "enc128", res);
        do_block(0, 10, CT4, 1'b1, 1'b1, PT0, 0, "dec128", res);
        do_block(1, 12, PT0, 1'b0, 1'b1, CT6, 0, "enc192", res);
        do_block(1, 12, CT6, 1'b1, 1'b1, PT0, 0, "dec192", res);
        do_block(2, 14, PT0, 1'b0, 1'b1, CT8, 0, "enc256", res);
        do_block(2, 14, CT8, 1'b1, 1'b1, PT0, 0, "dec256", res);

        // Key swapped while idle; consumer stalls for five cycles.
        full = key_expand(KEY1, 4); ek4 = full[1919 -: 1408];
        do_block(0, 10, PT1, 1'b0, 1'b1, CT1, 5, "enc_hold", res);
        do_block(0, 10, CT1, 1'b1, 1'b1, PT1, 0, "dec_b", res);

        // out_ready with nothing to consume leaves the core idle.
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("idle_out_ready", 128'({in_ready[0], out_valid[0], busy[0]}), 128'b100);

        // Back-to-back alternating directions with the consumer always ready.
        full = key_expand(KEY4, 4); ek4 = full[1919 -: 1408];
        b2b_data[0] = PT0; b2b_data[1] = CT4; b2b_data[2] = PT0; b2b_data[3] = CT4;
        b2b_exp[0]  = CT4; b2b_exp[1]  = PT0; b2b_exp[2]  = CT4; b2b_exp[3]  = PT0;
        b2b_dec = 4'b1010;
        sent = 0; got = 0; last_out = -1; cyc = 0;
        out_ready[0] = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (out_valid[0]) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("b2b_data", out_data[0], want);
                if (last_out >= 0) chk("b2b_interval", 128'(cyc - last_out), 128'd11);
                last_out = cyc;
                got++;
            end
            if (in_ready[0] && sent < 4) begin
                in_valid[0]   = 1'b1;
                in_data[0]    = b2b_data[sent];
                in_decrypt[0] = b2b_dec[sent];
                exp_q.push_back(b2b_exp[sent]);
                sent++;
            end else if (sent < 4) begin
                in_valid[0]   = 1'($urandom_range(0, 1));
                in_data[0]    = {$urandom, $urandom, $urandom, $urandom};
                in_decrypt[0] = 1'($urandom_range(0, 1));
            end else begin
                in_valid[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        chk("b2b_count", 128'(got), 128'd4);
        chk("b2b_idle", 128'({in_ready[0], out_valid[0]}), 128'b10);

        // Random keys and plaintexts: decrypt(encrypt(p)) must give p back.
        for (int n = 0; n < 3; n++) begin
            full   = key_expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4);
            ek4    = full[1919 -: 1408];
            rnd_pt = {$urandom, $urandom, $urandom, $urandom};
            do_block(0, 10, rnd_pt, 1'b0, 1'b0, '0, 0, "rt_enc", ct);
            do_block(0, 10, ct, 1'b1, 1'b1, rnd_pt, 0, "rt_dec", res);
        end

        // Reset in the middle of a block discards it entirely.
        full = key_expand(KEY4, 4); ek4 = full[1919 -: 1408];
        in_valid[0] = 1'b1; in_data[0] = PT0; in_decrypt[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 128'(busy[0]), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_flags", 128'({in_ready[0], out_valid[0], busy[0]}), 128'b100);
        chk("mid_reset_data", out_data[0], 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("mid_no_result", 128'(seen), 128'd0);
        do_block(0, 10, PT0, 1'b0, 1'b1, CT4, 0, "post_reset", res);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
